// File: rtl/alu_pkg.sv
// +-----------------------------------------------------------------------------+
// | alu_pkg: command codes, ALUop encodings, FSM states and CR bit indices for  |
// |          the ALU issue controller and its condition-register helper.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [2:0] CMD_AND = 3'd0;
  localparam logic [2:0] CMD_OR  = 3'd1;
  localparam logic [2:0] CMD_SUB = 3'd2;
  localparam logic [2:0] CMD_SLT = 3'd3;
  localparam logic [2:0] CMD_CMP = 3'd4;

  // Bit1 set means the ALU inverts B and injects carry-in 1.
  localparam logic [1:0] ALUOP_AND = 2'b00;
  localparam logic [1:0] ALUOP_OR  = 2'b01;
  localparam logic [1:0] ALUOP_SUB = 2'b10;
  localparam logic [1:0] ALUOP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CR_LT = 3;
  localparam int CR_GT = 2;
  localparam int CR_EQ = 1;
  localparam int CR_SO = 0;

  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd <= CMD_CMP);
  endfunction

  function automatic logic cmd_is_arith(input logic [2:0] cmd);
    return (cmd == CMD_SUB) || (cmd == CMD_SLT) || (cmd == CMD_CMP);
  endfunction

  function automatic logic [1:0] cmd_to_aluop(input logic [2:0] cmd);
    logic [1:0] op;
    case (cmd)
      CMD_OR:  op = ALUOP_OR;
      CMD_SUB: op = ALUOP_SUB;
      CMD_SLT: op = ALUOP_SLT;
      CMD_CMP: op = ALUOP_SUB;
      default: op = ALUOP_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cr_gen.sv
// +-----------------------------------------------------------------------------+
// | alu_cr_gen: combinational ALU flags -> {LT,GT,EQ}; shared with branch unit. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_cr_gen (
  input  logic arith,
  input  logic neg,
  input  logic ovf,
  input  logic zero,
  output logic lt,
  output logic gt,
  output logic eq
);

  // Signed ordering after a subtract must correct the sign bit for overflow.
  assign lt = arith ? (neg ^ ovf) : neg;
  assign eq = zero;
  assign gt = ~lt & ~eq;

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +-----------------------------------------------------------------------------+
// | alu_issue_ctrl: holds ALU operands for a settle window, samples the flags,  |
// |   builds {LT,GT,EQ,SO}. Optional self-check: define ALU_SELFCHECK_EN.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic [3:0]       rsp_cr,
  output logic             rsp_err,
  input  logic             clr_so,
  output logic             chk_err
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cmd_q;
  logic             so;
  logic             so_next;
  logic             accept;
  logic             legal;
  logic             capture;
  logic             arith_q;
  logic             lt;
  logic             gt;
  logic             eq;

  assign legal     = cmd_is_legal(req_cmd);
  assign accept    = (state == IDLE) && req_valid;
  assign capture   = (state == SETTLE) && (cnt == '0);
  assign arith_q   = cmd_is_arith(cmd_q);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // A new overflow at capture beats a simultaneous clear request.
  assign so_next = (capture && arith_q && alu_ovf) | (so & ~clr_so);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = legal ? SETTLE : RESP;
      SETTLE:  if (capture) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  alu_cr_gen u_cr_gen (
    .arith (arith_q),
    .neg   (alu_neg),
    .ovf   (alu_ovf),
    .zero  (alu_zero),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cnt        <= '0;
      cmd_q      <= '0;
      so         <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_cr     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      so <= so_next;

      if (accept && legal) begin
        alu_a  <= req_a;
        alu_b  <= req_b;
        alu_op <= cmd_to_aluop(req_cmd);
        cmd_q  <= req_cmd;
        cnt    <= CNT_W'(SETTLE_CYCLES - 1);
      end else if ((state == SETTLE) && !capture) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (accept && !legal) begin
        rsp_result    <= '0;
        rsp_carry     <= 1'b0;
        rsp_ovf       <= 1'b0;
        rsp_err       <= 1'b1;
        rsp_cr        <= '0;
        rsp_cr[CR_SO] <= so_next;
      end

      if (capture) begin
        rsp_result    <= (cmd_q == CMD_CMP) ? '0 : alu_result;
        rsp_carry     <= alu_carry;
        rsp_ovf       <= alu_ovf;
        rsp_err       <= 1'b0;
        rsp_cr[CR_LT] <= lt;
        rsp_cr[CR_GT] <= gt;
        rsp_cr[CR_EQ] <= eq;
        rsp_cr[CR_SO] <= so_next;
      end
    end
  end

`ifdef ALU_SELFCHECK_EN
  logic [WIDTH-1:0] expect_res;

  always_comb begin
    expect_res = '0;
    case (cmd_q)
      CMD_AND: expect_res = alu_a & alu_b;
      CMD_OR:  expect_res = alu_a | alu_b;
      CMD_SLT: expect_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: expect_res = alu_a - alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                                   chk_err <= 1'b0;
    else if (capture && (expect_res != alu_result)) chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_alu_issue_ctrl: table vectors, corner sequences and random commands      |
// |   against a behavioural reference model of the issue controller.            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_ovf;
  logic        alu_neg;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic [3:0]  rsp_cr;
  logic        rsp_err;
  logic        clr_so = 1'b0;
  logic        chk_err;
  logic        fault_en = 1'b0;

  int total = 0;
  int bad   = 0;
  logic so_model = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_cr(rsp_cr),
    .rsp_err(rsp_err), .clr_so(clr_so), .chk_err(chk_err)
  );

  // Ripple ALU stand-in; fault_en flips result bit 27.
  logic [32:0] sum;
  logic [31:0] res_raw;
  always_comb begin
    sum     = {1'b0, alu_a} + {1'b0, (alu_op[1] ? ~alu_b : alu_b)} + {32'd0, alu_op[1]};
    alu_ovf = alu_op[1] & (alu_a[31] != alu_b[31]) & (sum[31] != alu_a[31]);
    case (alu_op)
      2'b00:   res_raw = alu_a & alu_b;
      2'b01:   res_raw = alu_a | alu_b;
      2'b10:   res_raw = sum[31:0];
      default: res_raw = {31'd0, sum[31] ^ alu_ovf};
    endcase
    alu_result = res_raw ^ (fault_en ? 32'h0800_0000 : 32'h0);
    alu_carry  = alu_op[1] & sum[32];
    alu_neg    = alu_op[1] ? sum[31] : res_raw[31];
    alu_zero   = alu_op[1] ? (sum[31:0] == 32'd0) : (res_raw == 32'd0);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_op(input logic [2:0] cmd);
    case (cmd)
      3'd1:    return 2'b01;
      3'd2:    return 2'b10;
      3'd3:    return 2'b11;
      3'd4:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Reference from the command semantics: signed comparisons and exact arithmetic.
  task automatic ref_model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic clr_cap, output logic [31:0] r, output logic [3:0] cr,
                           output logic cy, output logic ov, output logic er);
    longint d;
    logic lt, eq, arith;
    d  = longint'($signed(a)) - longint'($signed(b));
    lt = $signed(a) < $signed(b);
    eq = (a == b);
    cy = 1'b0; ov = 1'b0; er = 1'b0; r = '0;
    arith = (cmd == 3'd2) || (cmd == 3'd3) || (cmd == 3'd4);
    if (arith) begin
      cy = (a >= b);
      ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    end
    case (cmd)
      3'd0: begin r = a & b; lt = r[31]; eq = (r == 0); end
      3'd1: begin r = a | b; lt = r[31]; eq = (r == 0); end
      3'd2: r = a - b;
      3'd3: r = lt ? 32'd1 : 32'd0;
      3'd4: r = 32'd0;
      default: begin er = 1'b1; lt = 1'b0; eq = 1'b0; end
    endcase
    if (!er) so_model = (arith && ov) ? 1'b1 : (clr_cap ? 1'b0 : so_model);
    cr = {lt, (!er && !lt && !eq), eq, so_model};
  endtask

  // clr_mode: 0 none, 1 clr_so at the capture edge, 2 clr_so during the response stall.
  task automatic run_cmd(input string nm, input logic [2:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_res, input logic [3:0] e_cr,
                         input logic e_cy, input logic e_ov, input logic e_err,
                         input int clr_mode, input int stall);
    logic [31:0] pa, pb;
    logic [1:0]  pop;
    int k;
    pa = alu_a; pb = alu_b; pop = alu_op;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    k = 1;
    if (e_err) check({nm, " alu_hold"}, {alu_a, alu_b, alu_op}, {pa, pb, pop});
    else       check({nm, " alu_drive"}, {alu_a, alu_b, alu_op, req_ready}, {a, b, exp_op(cmd), 1'b0});
    while (!rsp_valid && k < 40) begin
      if (clr_mode == 1 && k == SETTLE) clr_so = 1'b1;
      @(negedge clk);
      k++;
      clr_so = 1'b0;
    end
    check({nm, " latency"}, k, e_err ? 1 : SETTLE + 1);
    check({nm, " result"}, rsp_result, e_res);
    check({nm, " cr"}, rsp_cr, e_cr);
    check({nm, " cy/ov/err"}, {rsp_carry, rsp_ovf, rsp_err}, {e_cy, e_ov, e_err});
    for (int i = 0; i < stall; i++) begin
      if (clr_mode == 2 && i == 0) clr_so = 1'b1;
      @(negedge clk);
      clr_so = 1'b0;
      check({nm, " stall_hold"},
            {rsp_valid, req_ready, rsp_result, rsp_cr, rsp_carry, rsp_ovf, rsp_err},
            {1'b1, 1'b0, e_res, e_cr, e_cy, e_ov, e_err});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({nm, " handshake"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a, b, res;
    logic [3:0]  cr;
    logic        cy, ov, err;
    int          clr, stall;
  } vec_t;

  initial begin
    vec_t vt[11];
    logic [31:0] e_res;
    logic [3:0]  e_cr;
    logic        e_cy, e_ov, e_err;
    logic        seen;
    int          clr_m, st;
    logic [2:0]  c;
    logic [31:0] ra, rb;

    vt[0]  = '{3'd2, 32'd5,          32'd7,          32'hFFFF_FFFE, 4'b1000, 1'b0, 1'b0, 1'b0, 0, 10};
    vt[1]  = '{3'd4, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h0,         4'b0101, 1'b0, 1'b1, 1'b0, 0, 0};
    vt[2]  = '{3'd0, 32'hF0,         32'h0F,         32'h0,         4'b0011, 1'b0, 1'b0, 1'b0, 0, 0};
    vt[3]  = '{3'd1, 32'h8000_0000,  32'h1,          32'h8000_0001, 4'b1001, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[4]  = '{3'd3, 32'd3,          32'd3,          32'h0,         4'b0011, 1'b1, 1'b0, 1'b0, 0, 0};
    vt[5]  = '{3'd3, 32'hFFFF_FFFF,  32'd1,          32'h1,         4'b1001, 1'b1, 1'b0, 1'b0, 0, 0};
    vt[6]  = '{3'd2, 32'd10,         32'd3,          32'd7,         4'b0101, 1'b1, 1'b0, 1'b0, 0, 0};
    vt[7]  = '{3'd6, 32'h1234,       32'h5678,       32'h0,         4'b0001, 1'b0, 1'b0, 1'b1, 0, 2};
    vt[8]  = '{3'd2, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 4'b1001, 1'b1, 1'b1, 1'b0, 1, 0};
    vt[9]  = '{3'd0, 32'd0,          32'd0,          32'h0,         4'b0011, 1'b0, 1'b0, 1'b0, 2, 2};
    vt[10] = '{3'd1, 32'd1,          32'd2,          32'd3,         4'b0100, 1'b0, 1'b0, 1'b0, 0, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state",
          {alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_cr, rsp_carry, rsp_ovf, rsp_err, chk_err, req_ready},
          {32'd0, 32'd0, 2'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < 11; i++)
      run_cmd($sformatf("vec%0d", i), vt[i].cmd, vt[i].a, vt[i].b, vt[i].res, vt[i].cr,
              vt[i].cy, vt[i].ov, vt[i].err, vt[i].clr, vt[i].stall);

    // Next command already pending at the handshake: accepted one cycle later.
    req_valid = 1'b1; req_cmd = 3'd0; req_a = 32'h3; req_b = 32'h5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    check("b2b first_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_cmd = 3'd1; req_a = 32'hA0; req_b = 32'h0B;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("b2b ready_after_hs", {rsp_valid, req_ready, alu_a}, {1'b0, 1'b1, 32'h3});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b accepted", {req_ready, alu_a, alu_op}, {1'b0, 32'hA0, 2'b01});
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    check("b2b second_result", {rsp_valid, rsp_result, rsp_cr}, {1'b1, 32'hAB, 4'b0100});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of a settle window drops the command.
    req_valid = 1'b1; req_cmd = 3'd2; req_a = 32'h8000_0000; req_b = 32'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midsettle_reset",
          {alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_cr, rsp_carry, rsp_ovf, rsp_err, chk_err, req_ready},
          {32'd0, 32'd0, 2'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("no_rsp_after_reset", seen, 1'b0);
    so_model = 1'b0;

    for (int n = 0; n < 40; n++) begin
      c  = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = ra >> $urandom_range(0, 31);
        rb = rb >> $urandom_range(0, 31);
      end
      clr_m = $urandom_range(0, 2);
      if (c > 3'd4 && clr_m == 1) clr_m = 0;
      st = $urandom_range(0, 3);
      if (clr_m == 2 && st == 0) st = 1;
      ref_model(c, ra, rb, clr_m == 1, e_res, e_cr, e_cy, e_ov, e_err);
      run_cmd($sformatf("rnd%0d", n), c, ra, rb, e_res, e_cr, e_cy, e_ov, e_err, clr_m, st);
      if (clr_m == 2) so_model = 1'b0;
    end

    check("chk_err_clean", chk_err, 1'b0);
    fault_en = 1'b1;
    ref_model(3'd2, 32'd100, 32'd1, 1'b0, e_res, e_cr, e_cy, e_ov, e_err);
    run_cmd("fault", 3'd2, 32'd100, 32'd1, e_res ^ 32'h0800_0000, e_cr, e_cy, e_ov, e_err, 0, 0);
    fault_en = 1'b0;
`ifdef ALU_SELFCHECK_EN
    check("chk_err_fault", chk_err, 1'b1);
`else
    check("chk_err_fault", chk_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
